vmem_wr_arbiter: RTL and testbench

- Write-side controller for the 24-bit video frame buffer scanned out by the VGA path; the buffer is addressed as {h_addr, v_addr}.
- Arbitrates between two pixel-write requesters using valid/ready handshakes and round-robin priority.
- Contains a clear engine that fills the visible area with one colour.
- Can optionally restrict all writes to blanking intervals (display-inactive) to prevent tearing.

---
 rtl/vmem_wr_arbiter.sv | 158 +++++++++++++++
 tb/tb_vmem_wr_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_wr_arbiter.sv
// Write-side controller for the {h, v} addressed frame buffer: round-robin
// arbitration of two pixel writers, a full-screen clear engine and optional blanking-only writes.
module vmem_wr_arbiter #(
  parameter int H_BITS     = 10,
  parameter int V_BITS     = 9,
  parameter int DATA_W     = 24,
  parameter int H_MAX      = 640,
  parameter int V_MAX      = 480,
  parameter int BLANK_ONLY = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     vga_valid,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [H_BITS-1:0]        req0_h,
  input  logic [V_BITS-1:0]        req0_v,
  input  logic [DATA_W-1:0]        req0_data,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [H_BITS-1:0]        req1_h,
  input  logic [V_BITS-1:0]        req1_v,
  input  logic [DATA_W-1:0]        req1_data,
  input  logic                     clr_start,
  input  logic [DATA_W-1:0]        clr_color,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     mem_we,
  output logic [H_BITS+V_BITS-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     err_drop
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [H_BITS-1:0] H_LAST = H_BITS'(H_MAX - 1);
  localparam logic [V_BITS-1:0] V_LAST = V_BITS'(V_MAX - 1);
  localparam logic [H_BITS:0]   H_LIM  = (H_BITS+1)'(H_MAX);
  localparam logic [V_BITS:0]   V_LIM  = (V_BITS+1)'(V_MAX);

  state_t                     state_q, state_d;
  logic                       last_grant_q, last_grant_d;
  logic [H_BITS-1:0]          h_cnt_q, h_cnt_d;
  logic [V_BITS-1:0]          v_cnt_q, v_cnt_d;
  logic [DATA_W-1:0]          color_q, color_d;
  logic                       mem_we_q, mem_we_d;
  logic [H_BITS+V_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]          mem_wdata_q, mem_wdata_d;
  logic                       err_drop_q, err_drop_d;
  logic                       clr_done_q, clr_done_d;

  logic                       wr_ok;
  logic                       sel;
  logic                       rdy0, rdy1;
  logic [H_BITS-1:0]          sel_h;
  logic [V_BITS-1:0]          sel_v;
  logic [DATA_W-1:0]          sel_data;

  assign wr_ok = (BLANK_ONLY == 0) || !vga_valid;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    color_d      = color_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    err_drop_d   = 1'b0;
    clr_done_d   = 1'b0;
    rdy0         = 1'b0;
    rdy1         = 1'b0;
    // With both requesters valid the one that did not win last time goes next.
    sel          = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    sel_h        = sel ? req1_h    : req0_h;
    sel_v        = sel ? req1_v    : req0_v;
    sel_data     = sel ? req1_data : req0_data;

    case (state_q)
      IDLE: begin
        if (clr_start) begin
          color_d = clr_color;
          h_cnt_d = '0;
          v_cnt_d = '0;
          state_d = CLEAR;
        end else if (wr_ok && (req0_valid || req1_valid)) begin
          rdy0         = ~sel;
          rdy1         = sel;
          last_grant_d = sel;
          if (({1'b0, sel_h} >= H_LIM) || ({1'b0, sel_v} >= V_LIM)) begin
            err_drop_d = 1'b1;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {sel_h, sel_v};
            mem_wdata_d = sel_data;
          end
        end
      end
      CLEAR: begin
        if (wr_ok) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {h_cnt_q, v_cnt_q};
          mem_wdata_d = color_q;
          if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
              clr_done_d = 1'b1;
              state_d    = IDLE;
            end else begin
              v_cnt_d = v_cnt_q + V_BITS'(1);
            end
          end else begin
            h_cnt_d = h_cnt_q + H_BITS'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      color_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      err_drop_q   <= 1'b0;
      clr_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      color_q      <= color_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      err_drop_q   <= err_drop_d;
      clr_done_q   <= clr_done_d;
    end
  end

  // Readys are combinational, so they are forced low while reset is held.
  assign req0_ready = rdy0 & resetn;
  assign req1_ready = rdy1 & resetn;
  assign clr_busy   = (state_q == CLEAR);
  assign clr_done   = clr_done_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign err_drop   = err_drop_q;

endmodule

// File: tb/tb_vmem_wr_arbiter.sv
// Directed bench: dut_a is the full 640x480 arbiter, dut_b a small 8x4 blanking-only
// instance so a complete clear fits in a short run.
module tb_vmem_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic        a_resetn, a_vga_valid, a_req0_valid, a_req0_ready, a_req1_valid, a_req1_ready;
  logic [9:0]  a_req0_h, a_req1_h;
  logic [8:0]  a_req0_v, a_req1_v;
  logic [23:0] a_req0_data, a_req1_data, a_clr_color, a_mem_wdata;
  logic        a_clr_start, a_clr_busy, a_clr_done, a_mem_we, a_err_drop;
  logic [18:0] a_mem_addr;

  logic        b_resetn, b_vga_valid, b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
  logic [9:0]  b_req0_h, b_req1_h;
  logic [8:0]  b_req0_v, b_req1_v;
  logic [23:0] b_req0_data, b_req1_data, b_clr_color, b_mem_wdata;
  logic        b_clr_start, b_clr_busy, b_clr_done, b_mem_we, b_err_drop;
  logic [18:0] b_mem_addr;

  vmem_wr_arbiter dut_a (
    .clk(clk), .resetn(a_resetn), .vga_valid(a_vga_valid),
    .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_h(a_req0_h), .req0_v(a_req0_v), .req0_data(a_req0_data),
    .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_h(a_req1_h), .req1_v(a_req1_v), .req1_data(a_req1_data),
    .clr_start(a_clr_start), .clr_color(a_clr_color), .clr_busy(a_clr_busy), .clr_done(a_clr_done),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .err_drop(a_err_drop)
  );

  vmem_wr_arbiter #(.H_MAX(8), .V_MAX(4), .BLANK_ONLY(1)) dut_b (
    .clk(clk), .resetn(b_resetn), .vga_valid(b_vga_valid),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_h(b_req0_h), .req0_v(b_req0_v), .req0_data(b_req0_data),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_h(b_req1_h), .req1_v(b_req1_v), .req1_data(b_req1_data),
    .clr_start(b_clr_start), .clr_color(b_clr_color), .clr_busy(b_clr_busy), .clr_done(b_clr_done),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .err_drop(b_err_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_resetn = 1'b0; b_resetn = 1'b0;
    a_vga_valid = 1'b1; b_vga_valid = 1'b1;
    a_req0_valid = 1'b1; a_req1_valid = 1'b1; b_req0_valid = 1'b0; b_req1_valid = 1'b0;
    a_req0_h = '0; a_req0_v = '0; a_req0_data = '0; a_req1_h = '0; a_req1_v = '0; a_req1_data = '0;
    b_req0_h = '0; b_req0_v = '0; b_req0_data = '0; b_req1_h = '0; b_req1_v = '0; b_req1_data = '0;
    a_clr_start = 1'b0; a_clr_color = '0; b_clr_start = 1'b0; b_clr_color = '0;
    repeat (2) @(posedge clk);
    #2;
    vec_cnt++; if (a_req0_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_ready0: got %b want 0", a_req0_ready); end
    vec_cnt++; if (a_req1_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_ready1: got %b want 0", a_req1_ready); end
    vec_cnt++; if (a_mem_we !== 1'b0) begin err_cnt++; $display("FAIL reset_we: got %b want 0", a_mem_we); end
    vec_cnt++; if (a_mem_addr !== 19'h0) begin err_cnt++; $display("FAIL reset_addr: got %h want 0", a_mem_addr); end
    vec_cnt++; if (a_mem_wdata !== 24'h0) begin err_cnt++; $display("FAIL reset_wdata: got %h want 0", a_mem_wdata); end
    vec_cnt++; if ({a_clr_busy, a_clr_done, a_err_drop} !== 3'b000) begin err_cnt++; $display("FAIL reset_flags: got %b want 000", {a_clr_busy, a_clr_done, a_err_drop}); end
    a_req0_valid = 1'b0; a_req1_valid = 1'b0;
    @(negedge clk);
    a_resetn = 1'b1; b_resetn = 1'b1;
    tick();
    vec_cnt++; if (a_mem_we !== 1'b0) begin err_cnt++; $display("FAIL post_reset_we: got %b want 0", a_mem_we); end
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_round_robin();
    logic [18:0] exp_addr;
    logic [23:0] exp_data;
    a_req0_h = 10'd1; a_req0_v = 9'd1; a_req0_data = 24'h111111;
    a_req1_h = 10'd2; a_req1_v = 9'd2; a_req1_data = 24'h222222;
    a_req0_valid = 1'b1; a_req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (a_req0_ready !== (i % 2 == 0)) begin err_cnt++; $display("FAIL rr_ready0[%0d]: got %b want %b", i, a_req0_ready, (i % 2 == 0)); end
      vec_cnt++; if (a_req1_ready !== (i % 2 == 1)) begin err_cnt++; $display("FAIL rr_ready1[%0d]: got %b want %b", i, a_req1_ready, (i % 2 == 1)); end
      tick();
      exp_addr = (i % 2 == 0) ? {10'd1, 9'd1} : {10'd2, 9'd2};
      exp_data = (i % 2 == 0) ? 24'h111111 : 24'h222222;
      vec_cnt++; if (a_mem_we !== 1'b1 || a_mem_addr !== exp_addr || a_mem_wdata !== exp_data) begin
        err_cnt++; $display("FAIL rr_write[%0d]: got we=%b addr=%h data=%h want we=1 addr=%h data=%h", i, a_mem_we, a_mem_addr, a_mem_wdata, exp_addr, exp_data);
      end
      $display("round_robin: transfer %0d addr=%h data=%h", i, a_mem_addr, a_mem_wdata);
    end
    a_req0_valid = 1'b0; a_req1_valid = 1'b0;
    tick();
    vec_cnt++; if (a_mem_we !== 1'b0) begin err_cnt++; $display("FAIL rr_idle_we: got %b want 0", a_mem_we); end
  endtask

  task automatic test_single_write();
    a_req0_h = 10'd5; a_req0_v = 9'd7; a_req0_data = 24'hFF0000; a_req0_valid = 1'b1;
    #1;
    vec_cnt++; if (a_req0_ready !== 1'b1) begin err_cnt++; $display("FAIL single_ready: got %b want 1", a_req0_ready); end
    tick();
    a_req0_valid = 1'b0;
    vec_cnt++; if (a_mem_we !== 1'b1) begin err_cnt++; $display("FAIL single_we: got %b want 1", a_mem_we); end
    vec_cnt++; if (a_mem_addr !== 19'h00A07) begin err_cnt++; $display("FAIL single_addr: got %h want 00a07", a_mem_addr); end
    vec_cnt++; if (a_mem_wdata !== 24'hFF0000) begin err_cnt++; $display("FAIL single_wdata: got %h want ff0000", a_mem_wdata); end
    $display("single_write: addr=%h data=%h", a_mem_addr, a_mem_wdata);
    tick();
  endtask

  task automatic test_range_drop();
    a_req1_h = 10'd640; a_req1_v = 9'd0; a_req1_data = 24'h00FFFF; a_req1_valid = 1'b1;
    #1;
    vec_cnt++; if (a_req1_ready !== 1'b1) begin err_cnt++; $display("FAIL drop_h_ready: got %b want 1", a_req1_ready); end
    tick();
    a_req1_valid = 1'b0;
    vec_cnt++; if (a_err_drop !== 1'b1 || a_mem_we !== 1'b0) begin err_cnt++; $display("FAIL drop_h: got err=%b we=%b want err=1 we=0", a_err_drop, a_mem_we); end
    $display("range_drop: h=640 v=0 dropped");
    a_req0_h = 10'd639; a_req0_v = 9'd480; a_req0_valid = 1'b1;
    #1;
    vec_cnt++; if (a_req0_ready !== 1'b1) begin err_cnt++; $display("FAIL drop_v_ready: got %b want 1", a_req0_ready); end
    tick();
    a_req0_valid = 1'b0;
    vec_cnt++; if (a_err_drop !== 1'b1 || a_mem_we !== 1'b0) begin err_cnt++; $display("FAIL drop_v: got err=%b we=%b want err=1 we=0", a_err_drop, a_mem_we); end
    $display("range_drop: h=639 v=480 dropped");
    tick();
    vec_cnt++; if (a_err_drop !== 1'b0) begin err_cnt++; $display("FAIL drop_pulse_width: got %b want 0", a_err_drop); end
  endtask

  task automatic test_clear_reset_abort();
    int  writes = 0;
    bit  done_seen = 0;
    a_req0_h = 10'd3; a_req0_v = 9'd3; a_req0_data = 24'h0000AA; a_req0_valid = 1'b1;
    a_clr_color = 24'h123456; a_clr_start = 1'b1;
    #1;
    vec_cnt++; if (a_req0_ready !== 1'b0) begin err_cnt++; $display("FAIL clr_start_ready: got %b want 0", a_req0_ready); end
    tick();
    a_clr_start = 1'b0;
    vec_cnt++; if (a_clr_busy !== 1'b1 || a_mem_we !== 1'b0) begin err_cnt++; $display("FAIL clr_busy_start: got busy=%b we=%b want busy=1 we=0", a_clr_busy, a_mem_we); end
    for (int c = 0; c < 150 && writes < 100; c++) begin
      tick();
      if (a_clr_done === 1'b1) done_seen = 1;
      if (a_mem_we === 1'b1) begin
        if (writes == 0) begin
          vec_cnt++; if (a_mem_addr !== 19'h0 || a_mem_wdata !== 24'h123456) begin err_cnt++; $display("FAIL clr_first: got addr=%h data=%h want 00000 123456", a_mem_addr, a_mem_wdata); end
        end
        if (writes == 99) begin
          vec_cnt++; if (a_mem_addr !== {10'd99, 9'd0}) begin err_cnt++; $display("FAIL clr_100th: got addr=%h want %h", a_mem_addr, {10'd99, 9'd0}); end
        end
        writes++;
      end
    end
    vec_cnt++; if (writes != 100) begin err_cnt++; $display("FAIL clr_progress: got %0d writes want 100", writes); end
    #2;
    a_resetn = 1'b0;
    #1;
    vec_cnt++; if ({a_mem_we, a_clr_busy, a_clr_done, a_err_drop, a_req0_ready, a_req1_ready} !== 6'b0) begin
      err_cnt++; $display("FAIL abort_flags: got we=%b busy=%b done=%b err=%b rdy0=%b rdy1=%b want all 0", a_mem_we, a_clr_busy, a_clr_done, a_err_drop, a_req0_ready, a_req1_ready);
    end
    vec_cnt++; if (a_mem_addr !== 19'h0 || a_mem_wdata !== 24'h0) begin err_cnt++; $display("FAIL abort_bus: got addr=%h data=%h want 0", a_mem_addr, a_mem_wdata); end
    @(negedge clk);
    a_resetn = 1'b1;
    #1;
    vec_cnt++; if (a_clr_busy !== 1'b0 || a_req0_ready !== 1'b1) begin err_cnt++; $display("FAIL abort_idle: got busy=%b rdy0=%b want busy=0 rdy0=1", a_clr_busy, a_req0_ready); end
    vec_cnt++; if (done_seen) begin err_cnt++; $display("FAIL abort_done: clr_done seen=1 want 0"); end
    tick();
    a_req0_valid = 1'b0;
    vec_cnt++; if (a_mem_we !== 1'b1 || a_mem_addr !== {10'd3, 9'd3}) begin err_cnt++; $display("FAIL abort_write: got we=%b addr=%h want we=1 addr=%h", a_mem_we, a_mem_addr, {10'd3, 9'd3}); end
    $display("clear_abort: reset after %0d clear writes, idle afterwards", writes);
    tick();
  endtask

  task automatic test_blank_only();
    b_req0_h = 10'd2; b_req0_v = 9'd3; b_req0_data = 24'h00FF00; b_req0_valid = 1'b1; b_vga_valid = 1'b1;
    #1;
    vec_cnt++; if (b_req0_ready !== 1'b0) begin err_cnt++; $display("FAIL blank_active_ready: got %b want 0", b_req0_ready); end
    tick();
    vec_cnt++; if (b_req0_ready !== 1'b0 || b_mem_we !== 1'b0) begin err_cnt++; $display("FAIL blank_hold: got rdy=%b we=%b want 0 0", b_req0_ready, b_mem_we); end
    b_vga_valid = 1'b0;
    #1;
    vec_cnt++; if (b_req0_ready !== 1'b1) begin err_cnt++; $display("FAIL blank_open_ready: got %b want 1", b_req0_ready); end
    tick();
    b_req0_valid = 1'b0;
    vec_cnt++; if (b_mem_we !== 1'b1 || b_mem_addr !== {10'd2, 9'd3} || b_mem_wdata !== 24'h00FF00) begin
      err_cnt++; $display("FAIL blank_write: got we=%b addr=%h data=%h want 1 %h 00ff00", b_mem_we, b_mem_addr, b_mem_wdata, {10'd2, 9'd3});
    end
    $display("blank_only: write accepted once vga_valid dropped");
    tick();
  endtask

  task automatic test_clear_full();
    int  n = 0;
    bit  done_seen = 0;
    logic [18:0] exp_addr;
    b_req0_h = 10'd1; b_req0_v = 9'd1; b_req0_data = 24'h0000AA; b_req0_valid = 1'b1;
    b_clr_color = 24'h123456; b_clr_start = 1'b1;
    #1;
    vec_cnt++; if (b_req0_ready !== 1'b0) begin err_cnt++; $display("FAIL full_start_ready: got %b want 0", b_req0_ready); end
    tick();
    b_clr_start = 1'b0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      tick();
      if (b_mem_we === 1'b1) begin
        exp_addr = {10'(n % 8), 9'(n / 8)};
        vec_cnt++; if (b_mem_addr !== exp_addr || b_mem_wdata !== 24'h123456) begin err_cnt++; $display("FAIL full_write[%0d]: got addr=%h data=%h want %h 123456", n, b_mem_addr, b_mem_wdata, exp_addr); end
        n++;
      end
    end
    // Display-active stall, with a second clr_start that must be ignored.
    b_vga_valid = 1'b1; b_clr_start = 1'b1; b_clr_color = 24'hABCDEF;
    for (int s = 0; s < 3; s++) begin
      tick();
      b_clr_start = 1'b0;
      vec_cnt++; if (b_mem_we !== 1'b0 || b_clr_busy !== 1'b1) begin err_cnt++; $display("FAIL full_stall[%0d]: got we=%b busy=%b want 0 1", s, b_mem_we, b_clr_busy); end
    end
    b_vga_valid = 1'b0;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      tick();
      if (b_mem_we === 1'b1) begin
        exp_addr = {10'(n % 8), 9'(n / 8)};
        vec_cnt++; if (b_mem_addr !== exp_addr || b_mem_wdata !== 24'h123456) begin err_cnt++; $display("FAIL full_write[%0d]: got addr=%h data=%h want %h 123456", n, b_mem_addr, b_mem_wdata, exp_addr); end
        n++;
      end
      if (b_clr_done === 1'b1) begin
        done_seen = 1;
        vec_cnt++; if (b_mem_we !== 1'b1 || n != 32 || b_mem_addr !== {10'd7, 9'd3}) begin err_cnt++; $display("FAIL full_done: got we=%b writes=%0d addr=%h want 1 32 %h", b_mem_we, n, b_mem_addr, {10'd7, 9'd3}); end
        vec_cnt++; if (b_clr_busy !== 1'b0 || b_req0_ready !== 1'b1) begin err_cnt++; $display("FAIL full_release: got busy=%b rdy0=%b want 0 1", b_clr_busy, b_req0_ready); end
      end else if (b_clr_busy !== 1'b1) begin
        vec_cnt++; err_cnt++; $display("FAIL full_busy: got busy=%b want 1 before done (writes=%0d)", b_clr_busy, n);
      end
    end
    vec_cnt++; if (!done_seen) begin err_cnt++; $display("FAIL full_timeout: clr_done got 0 want 1 after %0d writes", n); end
    $display("clear_full: %0d clear writes observed", n);
    tick();
    b_req0_valid = 1'b0;
    vec_cnt++; if (b_mem_we !== 1'b1 || b_mem_addr !== {10'd1, 9'd1} || b_mem_wdata !== 24'h0000AA) begin
      err_cnt++; $display("FAIL full_after: got we=%b addr=%h data=%h want 1 %h 0000aa", b_mem_we, b_mem_addr, b_mem_wdata, {10'd1, 9'd1});
    end
    tick();
  endtask

  initial begin
    test_reset();
    a_vga_valid = 1'b0; b_vga_valid = 1'b0;
    test_round_robin();
    test_single_write();
    test_range_drop();
    test_clear_reset_abort();
    test_blank_only();
    test_clear_full();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
